instruction_fetch_queue: RTL and testbench

Fetch front end that sits directly upstream of the CPU decode/execute stage. It owns the fetch PC and issues reads to the synchronous instruction memory, which returns data one cycle after each read. Returned instructions are buffered in a small FIFO and presented to the CPU with a valid/ready handshake. Taken jumps, calls, exits and resets arrive as a redirect, which flushes the queue and restarts fetch at a new PC.

---
 rtl/instruction_fetch_queue_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instruction_fetch_queue.sv | 89 ++++++++
 tb/tb_instruction_fetch_queue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared widths, queue sizing, fetch state encoding and queue entry layout.
// Pure definitions: no latency, no backpressure.
package instruction_fetch_queue_pkg;

  localparam int PC_WIDTH          = 8;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int QUEUE_DEPTH       = 4;
  localparam int PTR_WIDTH         = $clog2(QUEUE_DEPTH);
  localparam int COUNT_WIDTH       = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Flushable synchronous FIFO of {pc, instruction} entries; a push is visible at the head next cycle.
// Backpressure: caller must not push when full; flush empties the queue and overrides push/pop.
module fetch_fifo
  import instruction_fetch_queue_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  fetch_entry_t           push_dat,
  input  logic                   pop_rdy,
  output fetch_entry_t           pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  fetch_entry_t       mem_q [QUEUE_DEPTH];
  fetch_entry_t       mem_d [QUEUE_DEPTH];
  logic               push, pop;

  // Extra pointer bit separates full (msb differs) from empty (all equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                   (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
  assign count   = COUNT_WIDTH'(wr_ptr_q - rd_ptr_q);
  assign push    = push_vld && !full && !flush;
  assign pop     = pop_rdy && !empty && !flush;
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PTR_WIDTH-1:0]] = push_dat;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  push_into_full_a: assert property (@(posedge clk) disable iff (rst) !(push_vld && full && !flush));

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the fetch PC, reads a 1-cycle memory and queues returned words for decode.
// Latency: issue to valid head 2 cycles; backpressure: reads stop while queued + in-flight reaches depth.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
(
  input  logic                         clock,
  input  logic                         isReset,
  output logic                         memRead,
  output logic [PC_WIDTH-1:0]          memAddress,
  input  logic [INSTRUCTION_WIDTH-1:0] memInstruction,
  input  logic                         redirect,
  input  logic [PC_WIDTH-1:0]          redirectPc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instructionPc,
  output logic                         instructionValid,
  input  logic                         instructionReady,
  output logic [COUNT_WIDTH-1:0]       queueCount
);

  localparam logic [COUNT_WIDTH:0] DEPTH_LIMIT = (COUNT_WIDTH + 1)'(QUEUE_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  pending_q, pending_d;
  logic                  issue_vld, flush_vld;
  logic                  queue_full, queue_empty;
  logic [COUNT_WIDTH:0]  in_flight;
  fetch_entry_t          resp_dat, head_dat;

  // Same-cycle pops are not credited, so the queue can never overflow.
  assign in_flight = {1'b0, queueCount} + (COUNT_WIDTH + 1)'(pending_q);
  assign flush_vld = (state_q == FETCH) && redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = 1'b0;
    issue_vld  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        issue_vld = !redirect && !queue_full && (in_flight < DEPTH_LIMIT);
        pending_d = issue_vld;
        if (redirect) begin
          fetch_pc_d = redirectPc;
        end else if (issue_vld) begin
          fetch_pc_d = fetch_pc_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
    end
  end

  assign memRead    = issue_vld;
  assign memAddress = fetch_pc_q;

  // The PC has already advanced past the read whose data is arriving now.
  assign resp_dat.pc          = fetch_pc_q - 1'b1;
  assign resp_dat.instruction = memInstruction;

  fetch_fifo u_fetch_fifo (
    .clk      (clock),
    .rst      (isReset),
    .flush    (flush_vld),
    .push_vld (pending_q),
    .push_dat (resp_dat),
    .pop_rdy  (instructionReady),
    .pop_dat  (head_dat),
    .full     (queue_full),
    .empty    (queue_empty),
    .count    (queueCount)
  );

  assign instruction      = head_dat.instruction;
  assign instructionPc    = head_dat.pc;
  assign instructionValid = !queue_empty;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomised scoreboard bench for instruction_fetch_queue with a PC-stream reference model.
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  logic                         clock;
  logic                         isReset;
  logic                         memRead;
  logic [PC_WIDTH-1:0]          memAddress;
  logic [INSTRUCTION_WIDTH-1:0] memInstruction;
  logic                         redirect;
  logic [PC_WIDTH-1:0]          redirectPc;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [PC_WIDTH-1:0]          instructionPc;
  logic                         instructionValid;
  logic                         instructionReady;
  logic [COUNT_WIDTH-1:0]       queueCount;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_queue dut (
    .clock            (clock),
    .isReset          (isReset),
    .memRead          (memRead),
    .memAddress       (memAddress),
    .memInstruction   (memInstruction),
    .redirect         (redirect),
    .redirectPc       (redirectPc),
    .instruction      (instruction),
    .instructionPc    (instructionPc),
    .instructionValid (instructionValid),
    .instructionReady (instructionReady),
    .queueCount       (queueCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hA000_0000 + {24'h0, a};
  endfunction

  // Synchronous instruction memory; junk on the bus whenever no read was issued.
  always @(posedge clock) begin
    if (memRead) memInstruction <= mem_word(memAddress);
    else         memInstruction <= $urandom();
  end

  // Reference model: count of entries owed to the CPU plus the stream of expected {pc, data}.
  typedef struct {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m_e;
  bit         m_fetch = 1'b0;
  bit         m_pend = 1'b0;
  bit         m_rd;
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_issue_pc = 8'h00;
  int         m_count = 0;

  function automatic bit model_read();
    return m_fetch && !redirect && ((m_count + int'(m_pend)) < QUEUE_DEPTH);
  endfunction

  always @(posedge clock or posedge isReset) begin
    if (isReset) begin
      m_fetch = 1'b0;
      m_pc    = 8'h00;
      m_pend  = 1'b0;
      m_count = 0;
      exp_q.delete();
    end else if (!m_fetch) begin
      m_fetch = 1'b1;
    end else if (redirect) begin
      m_pc    = redirectPc;
      m_pend  = 1'b0;
      m_count = 0;
      exp_q.delete();
    end else begin
      m_rd = model_read();
      if (m_count > 0 && instructionReady) m_count--;
      if (m_pend) begin
        m_e.pc   = m_issue_pc;
        m_e.data = mem_word(m_issue_pc);
        exp_q.push_back(m_e);
        m_count++;
      end
      m_pend = m_rd;
      if (m_rd) begin
        m_issue_pc = m_pc;
        m_pc       = m_pc + 8'd1;
      end
    end
  end

  // Monitor: compares every cycle away from the active edge and retires consumed entries.
  always @(negedge clock) begin
    check("memRead", 32'(memRead), 32'(model_read()));
    check("memAddress", 32'(memAddress), 32'(m_pc));
    check("queueCount", 32'(queueCount), 32'(m_count));
    check("instructionValid", 32'(instructionValid), 32'(m_count > 0));
    if (isReset) begin
      check("reset_instruction", instruction, 32'h0);
      check("reset_instructionPc", 32'(instructionPc), 32'h0);
    end
    if (exp_q.size() > 0) begin
      if (instructionValid) begin
        check("head_pc", 32'(instructionPc), 32'(exp_q[0].pc));
        check("head_data", instruction, exp_q[0].data);
      end
      if (instructionReady && !redirect && !isReset) void'(exp_q.pop_front());
    end
  end

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  task automatic drive();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_read(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      mid();
      if (memRead) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      mid();
      if (instructionValid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         ok;
    logic [7:0] wrap_pcs [4];
    wrap_pcs = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    isReset          = 1'b1;
    redirect         = 1'b0;
    redirectPc       = 8'h00;
    instructionReady = 1'b0;
    @(posedge clock);
    mid();
    check("reset_memRead", 32'(memRead), 32'h0);
    check("reset_valid", 32'(instructionValid), 32'h0);
    check("reset_count", 32'(queueCount), 32'h0);
    check("reset_instr", instruction, 32'h0);
    check("reset_pc", 32'(instructionPc), 32'h0);

    // Streaming with the CPU always ready.
    drive();
    isReset          = 1'b0;
    instructionReady = 1'b1;
    wait_read(5, ok);
    check("stream_first_read_seen", 32'(ok), 32'h1);
    check("stream_first_addr", 32'(memAddress), 32'h0);
    mid();
    check("stream_valid_too_early", 32'(instructionValid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      mid();
      check("stream_valid", 32'(instructionValid), 32'h1);
      check("stream_pc", 32'(instructionPc), k);
      check("stream_data", instruction, 32'hA000_0000 + k);
    end

    // Redirect while reads are in flight.
    drive();
    redirect   = 1'b1;
    redirectPc = 8'h40;
    mid();
    check("redir_no_read", 32'(memRead), 32'h0);
    drive();
    redirect = 1'b0;
    mid();
    check("redir_read", 32'(memRead), 32'h1);
    check("redir_addr", 32'(memAddress), 32'h40);
    check("redir_count0_a", 32'(queueCount), 32'h0);
    mid();
    check("redir_count0_b", 32'(queueCount), 32'h0);
    check("redir_stale_dropped", 32'(instructionValid), 32'h0);
    mid();
    check("redir_valid", 32'(instructionValid), 32'h1);
    check("redir_pc", 32'(instructionPc), 32'h40);

    // Back-to-back redirects while the head is being popped; the last one wins.
    repeat (3) mid();
    drive();
    redirect   = 1'b1;
    redirectPc = 8'h10;
    drive();
    redirectPc = 8'h20;
    drive();
    redirect = 1'b0;
    wait_valid(6, ok);
    check("b2b_valid_seen", 32'(ok), 32'h1);
    check("b2b_first_pc", 32'(instructionPc), 32'h20);

    // PC wrap-around.
    drive();
    redirect   = 1'b1;
    redirectPc = 8'hFE;
    drive();
    redirect = 1'b0;
    wait_valid(6, ok);
    check("wrap_valid_seen", 32'(ok), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("wrap_pc", 32'(instructionPc), 32'(wrap_pcs[i]));
      mid();
    end

    // Random traffic: ready stalls and occasional redirects.
    for (int c = 0; c < 300; c++) begin
      drive();
      instructionReady = ($urandom_range(0, 3) != 0);
      redirect         = ($urandom_range(0, 15) == 0);
      redirectPc       = 8'($urandom());
    end
    drive();
    redirect = 1'b0;

    // Fill to three entries, then reset between clock edges.
    drive();
    redirect         = 1'b1;
    redirectPc       = 8'h80;
    instructionReady = 1'b0;
    drive();
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (queueCount == 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("midrst_reached_count3", 32'(ok), 32'h1);
    #1 isReset = 1'b1;
    #1;
    check("midrst_memRead", 32'(memRead), 32'h0);
    check("midrst_valid", 32'(instructionValid), 32'h0);
    check("midrst_count", 32'(queueCount), 32'h0);
    drive();
    drive();
    isReset = 1'b0;

    // Restart at PC 0 under full backpressure.
    wait_read(5, ok);
    check("restart_read_seen", 32'(ok), 32'h1);
    check("restart_addr", 32'(memAddress), 32'h0);
    repeat (8) mid();
    check("bp_count_sat", 32'(queueCount), 32'h4);
    check("bp_no_read", 32'(memRead), 32'h0);
    check("bp_head_pc", 32'(instructionPc), 32'h0);
    drive();
    instructionReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      check("bp_drain_valid", 32'(instructionValid), 32'h1);
      check("bp_drain_pc", 32'(instructionPc), i);
    end

    for (int c = 0; c < 200; c++) begin
      drive();
      instructionReady = ($urandom_range(0, 2) != 0);
      redirect         = ($urandom_range(0, 11) == 0);
      redirectPc       = 8'($urandom());
    end
    drive();
    redirect = 1'b0;
    repeat (4) mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
